// File: rtl/viterbi_frame_sequencer.sv
// Frame scheduler for the Viterbi datapath: symbol intake, stage-enable pipeline, survivor writes, traceback.
// Optional abort input is compiled in when VITERBI_ABORT_EN is defined.
module viterbi_frame_sequencer #(
    parameter int FRAME_LEN = 12,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VITERBI_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             en_extract,
    output logic             en_branch,
    output logic             en_add,
    output logic             en_memory,
    output logic [CNT_W-1:0] wr_addr,
    output logic             en_traceback,
    output logic [CNT_W-1:0] tb_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_TRACE,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] LEN  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] tb_q, tb_d;
    logic             p1_q, p1_d;
    logic             p2_q, p2_d;
    logic             acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            in_cnt_q <= '0;
            wr_q     <= '0;
            tb_q     <= '0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            wr_q     <= wr_d;
            tb_q     <= tb_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        wr_d         = wr_q;
        tb_d         = tb_q;
        p1_d         = 1'b0;
        p2_d         = 1'b0;
        acc          = 1'b0;
        sym_ready    = 1'b0;
        en_extract   = 1'b0;
        en_branch    = 1'b0;
        en_add       = 1'b0;
        en_memory    = 1'b0;
        en_traceback = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    in_cnt_d = '0;
                    wr_d     = '0;
                    tb_d     = '0;
                end
            end
            S_LOAD: begin
                sym_ready  = (in_cnt_q < LEN);
                acc        = sym_valid & sym_ready;
                en_extract = acc;
                p1_d       = acc;
                p2_d       = p1_q;
                en_branch  = p1_q;
                en_add     = p1_q;
                en_memory  = p2_q;
                if (acc) in_cnt_d = in_cnt_q + 1'b1;
                // Address saturates at the last slot so a frame never wraps.
                if (p2_q && wr_q != LAST) wr_d = wr_q + 1'b1;
                if (acc && in_cnt_q == LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                p2_d      = p1_q;
                en_branch = p1_q;
                en_add    = p1_q;
                en_memory = p2_q;
                if (p2_q) begin
                    if (wr_q == LAST) begin
                        state_d = S_TRACE;
                        tb_d    = LAST;
                    end else begin
                        wr_d = wr_q + 1'b1;
                    end
                end
            end
            S_TRACE: begin
                en_traceback = 1'b1;
                en_memory    = 1'b1;
                out_valid    = 1'b1;
                if (out_ready) begin
                    if (tb_q == '0) state_d = S_DONE;
                    else            tb_d    = tb_q - 1'b1;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_d  = S_IDLE;
                in_cnt_d = '0;
                wr_d     = '0;
                tb_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef VITERBI_ABORT_EN
        // Abort discards the frame; only reset outranks it.
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            in_cnt_d = '0;
            wr_d     = '0;
            tb_d     = '0;
            p1_d     = 1'b0;
            p2_d     = 1'b0;
            done     = 1'b0;
        end
`endif
    end

    assign wr_addr = wr_q;
    assign tb_addr = tb_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_viterbi_frame_sequencer.sv
// Scoreboard bench for viterbi_frame_sequencer: expected events queued per frame, monitor pops on DUT activity.
module tb_viterbi_frame_sequencer;
    localparam int FL = 12;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst, start, sym_valid, out_ready, abort;
    logic sym_ready, en_extract, en_branch, en_add, en_memory, en_traceback, out_valid, busy, done;
    logic [CW-1:0] wr_addr, tb_addr;

    viterbi_frame_sequencer #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
`ifdef VITERBI_ABORT_EN
        .abort(abort),
`endif
        .start(start), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .en_extract(en_extract), .en_branch(en_branch), .en_add(en_add),
        .en_memory(en_memory), .wr_addr(wr_addr), .en_traceback(en_traceback),
        .tb_addr(tb_addr), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int val; int cyc;} exp_t;
    exp_t q_ext[$];
    exp_t q_wr[$];
    exp_t q_tb[$];
    exp_t q_done[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at frame cycle %0d", nm, cyc - base);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst) begin
            if (en_extract) begin
                if (q_ext.size() == 0) unexpected("extract");
                else begin e = q_ext.pop_front(); chk("extract_cycle", cyc - base, e.cyc); end
            end
            if (en_memory && !en_traceback) begin
                if (q_wr.size() == 0) unexpected("write");
                else begin
                    e = q_wr.pop_front();
                    chk("wr_addr", int'(wr_addr), e.val);
                    chk("write_cycle", cyc - base, e.cyc);
                end
            end
            if (out_valid && out_ready) begin
                if (q_tb.size() == 0) unexpected("trace");
                else begin
                    e = q_tb.pop_front();
                    chk("tb_addr", int'(tb_addr), e.val);
                    chk("trace_cycle", cyc - base, e.cyc);
                end
            end
            if (done) begin
                if (q_done.size() == 0) unexpected("done");
                else begin e = q_done.pop_front(); chk("done_cycle", cyc - base, e.cyc); end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_flags"}, int'({sym_ready, en_extract, en_branch, en_add, en_memory,
                                  en_traceback, out_valid, busy, done}), 0);
        chk({nm, "_wr_addr"}, int'(wr_addr), 0);
        chk({nm, "_tb_addr"}, int'(tb_addr), 0);
    endtask

    // alt: sym_valid on odd cycles only; stall: out_ready low 3 cycles at tb_addr=5;
    // glitch: extra start pulses during LOAD (cycle 5) and TRACE (cycle 18).
    task automatic run_frame(input bit alt, input bit stall, input bit glitch);
        int acc_c[FL];
        bit br[0:127];
        int last_acc, t0, dcyc, a;
        for (int i = 0; i < 128; i++) br[i] = 1'b0;
        for (int i = 0; i < FL; i++) begin
            acc_c[i] = alt ? (2 * i + 1) : (i + 1);
            br[acc_c[i] + 1] = 1'b1;
            q_ext.push_back('{1, acc_c[i]});
            q_wr.push_back('{i, acc_c[i] + 2});
        end
        last_acc = acc_c[FL-1];
        t0 = last_acc + 3;
        for (int k = 0; k < FL; k++) begin
            a = FL - 1 - k;
            q_tb.push_back('{a, t0 + k + ((stall && a <= 5) ? 3 : 0)});
        end
        dcyc = t0 + FL + (stall ? 3 : 0);
        q_done.push_back('{1, dcyc});

        base = cyc;
        for (int c = 0; c <= dcyc + 2; c++) begin
            start     = (c == 0) || (glitch && (c == 5 || c == 18));
            sym_valid = alt ? (c % 2 == 1) : 1'b1;
            out_ready = !(stall && c >= t0 + 6 && c <= t0 + 8);
            chk("sym_ready", int'(sym_ready), int'(c >= 1 && c <= last_acc));
            chk("en_branch", int'(en_branch), int'(br[c]));
            if (stall && c >= t0 + 6 && c <= t0 + 8) begin
                chk("stall_tb_addr", int'(tb_addr), 5);
                chk("stall_out_valid", int'(out_valid), 1);
            end
            if (c == dcyc + 1) chk("busy_after_done", int'(busy), 0);
            tick();
        end
        start = 1'b0; sym_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("ext_left", q_ext.size(), 0);
        chk("wr_left", q_wr.size(), 0);
        chk("tb_left", q_tb.size(), 0);
        chk("done_left", q_done.size(), 0);
        q_ext.delete(); q_wr.delete(); q_tb.delete(); q_done.delete();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; sym_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
        tick(); tick();
        chk_quiet("reset");
        rst = 1'b1;
        tick();

        // Reset mid-LOAD discards the partial frame.
        start = 1'b1; sym_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midload_busy", int'(busy), 1);
        rst = 1'b0;
        tick();
        chk_quiet("rst_midload");
        tick();
        rst = 1'b1; sym_valid = 1'b0;
        chk_quiet("rst_held");
        tick();
        chk_quiet("after_rst");

        mon_en = 1'b1;
        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1);

`ifdef VITERBI_ABORT_EN
        mon_en = 1'b0;
        start = 1'b1; sym_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 7; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; sym_valid = 1'b0;
        chk_quiet("abort");
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", int'(done), 0);
            tick();
        end
        mon_en = 1'b1;
        run_frame(1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
